// File: rtl/frame_save_controller.sv
// rtl/frame_save_controller.sv - 2:1 decimating frame grabber feeding a frame store through a small write FIFO.
// Optional macro FRAME_SAVE_CHECKSUM_EN adds a 16-bit running sum of written pixels.
module frame_save_controller #(
  parameter int IMG_WIDTH  = 320,
  parameter int IMG_HEIGHT = 240,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic                                    pclk,
  input  logic                                    save_req,
  input  logic                                    v_sync,
  input  logic                                    DE,
  input  logic [9:0]                              x_pixel,
  input  logic [9:0]                              y_pixel,
  input  logic [3:0]                              pix_r,
  input  logic [3:0]                              pix_g,
  input  logic [3:0]                              pix_b,
  output logic                                    wr_valid,
  input  logic                                    wr_ready,
  output logic [$clog2(IMG_WIDTH*IMG_HEIGHT)-1:0] wr_addr,
  output logic [11:0]                             wr_data,
  output logic                                    busy,
  output logic                                    done,
  output logic                                    overrun
`ifdef FRAME_SAVE_CHECKSUM_EN
  ,
  output logic [15:0]                             checksum
`endif
);
  localparam int NPIX = IMG_WIDTH * IMG_HEIGHT;
  localparam int AW   = $clog2(NPIX);
  localparam int CW   = $clog2(NPIX + 1);
  localparam int PW   = $clog2(FIFO_DEPTH);
  localparam logic [10:0]   X_LIM    = 11'(2 * IMG_WIDTH);
  localparam logic [10:0]   Y_LIM    = 11'(2 * IMG_HEIGHT);
  localparam logic [CW-1:0] LAST     = CW'(NPIX - 1);
  localparam logic [PW:0]   FULL_CNT = (PW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT_VS, CAPTURE, DRAIN} state_t;

  state_t            state_q;
  logic              vs_q;
  logic [CW-1:0]     cnt_q;
  logic [AW+11:0]    mem_q [FIFO_DEPTH];
  logic [PW-1:0]     rd_q;
  logic [PW-1:0]     wr_q;
  logic [PW:0]       fill_q;
  logic              busy_q;
  logic              done_q;
  logic              ovr_q;
`ifdef FRAME_SAVE_CHECKSUM_EN
  logic [15:0]       csum_q;
`endif

  logic              empty;
  logic              full;
  logic              vs_fall;
  logic              sample;
  logic              pop;
  logic              push;
  logic [CW-1:0]     cnt_d;
  logic [PW:0]       fill_d;
  logic [AW+11:0]    head;

  always_comb begin
    empty   = (fill_q == '0);
    full    = (fill_q == FULL_CNT);
    vs_fall = vs_q & ~v_sync;
    sample  = (state_q == CAPTURE) & pclk & DE & ~x_pixel[0] & ~y_pixel[0] &
              ({1'b0, x_pixel} < X_LIM) & ({1'b0, y_pixel} < Y_LIM);
    pop     = ~empty & wr_ready;
    // A full FIFO still takes a sample when the head leaves on the same edge.
    push    = sample & (~full | pop);
    cnt_d   = cnt_q + CW'(1);
    fill_d  = fill_q + (PW + 1)'(push) - (PW + 1)'(pop);
    head    = mem_q[rd_q];
  end

  assign wr_valid = ~empty;
  assign wr_addr  = head[AW+11:12];
  assign wr_data  = head[11:0];
  assign busy     = busy_q;
  assign done     = done_q;
  assign overrun  = ovr_q;
`ifdef FRAME_SAVE_CHECKSUM_EN
  assign checksum = csum_q;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      vs_q    <= 1'b1;
      cnt_q   <= '0;
      rd_q    <= '0;
      wr_q    <= '0;
      fill_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovr_q   <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
`ifdef FRAME_SAVE_CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      vs_q   <= v_sync;
      done_q <= 1'b0;
      fill_q <= fill_d;
      if (push) begin
        // The address is the sample index, so drops never shift later pixels.
        mem_q[wr_q] <= {cnt_q[AW-1:0], pix_r, pix_g, pix_b};
        wr_q        <= wr_q + PW'(1);
      end
      if (pop) begin
        rd_q <= rd_q + PW'(1);
`ifdef FRAME_SAVE_CHECKSUM_EN
        csum_q <= csum_q + {4'h0, head[11:0]};
`endif
      end
      case (state_q)
        IDLE: begin
          if (save_req) begin
            state_q <= WAIT_VS;
            busy_q  <= 1'b1;
            ovr_q   <= 1'b0;
            cnt_q   <= '0;
`ifdef FRAME_SAVE_CHECKSUM_EN
            csum_q  <= '0;
`endif
          end
        end
        WAIT_VS: begin
          if (vs_fall) state_q <= CAPTURE;
        end
        CAPTURE: begin
          if (sample) begin
            cnt_q <= cnt_d;
            if (!push) ovr_q <= 1'b1;
            if (cnt_q == LAST) state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (empty) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule
